// File: rtl/mem_bus_arbiter_2_if.sv
// Request/grant bundle between two bus requesters and the round-robin arbiter.
// The master side issues requests and completion; the slave side is the arbiter.
interface mem_bus_arbiter_2_if;
    logic Req_0;
    logic Req_1;
    logic Done;
    logic Grant_0;
    logic Grant_1;
    logic MuxSel;
    logic MuxEnable;
    logic Timeout;
    logic Busy;

    modport master (
        output Req_0,
        output Req_1,
        output Done,
        input  Grant_0,
        input  Grant_1,
        input  MuxSel,
        input  MuxEnable,
        input  Timeout,
        input  Busy
    );

    modport slave (
        input  Req_0,
        input  Req_1,
        input  Done,
        output Grant_0,
        output Grant_1,
        output MuxSel,
        output MuxEnable,
        output Timeout,
        output Busy
    );
endinterface

// File: rtl/mem_bus_arbiter_2.sv
// Two-requester round-robin bus arbiter driving a 2:1 mux, with a watchdog on
// open grants and a mandatory idle turnaround cycle between grants.
module mem_bus_arbiter_2 #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_WIDTH      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_bus_arbiter_2_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 timeout_q, timeout_d;
    logic                 grant_0_q, grant_0_d;
    logic                 grant_1_q, grant_1_d;
    logic                 mux_sel_q, mux_sel_d;
    logic                 mux_en_q, mux_en_d;
    logic                 busy_q, busy_d;

    logic                 owner;
    logic                 owner_req;

    // Requester currently holding the bus, and whether it still wants it.
    assign owner     = (state_q == GNT1);
    assign owner_req = owner ? bus.Req_1 : bus.Req_0;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.Req_0 && bus.Req_1) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (bus.Req_0) begin
                    state_d = GNT0;
                end else if (bus.Req_1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                // Done beats abort beats watchdog; all three release to IDLE.
                if (bus.Done || !owner_req || (cnt_q == CNT_LIMIT)) begin
                    state_d   = IDLE;
                    last_d    = owner;
                    cnt_d     = '0;
                    timeout_d = !bus.Done && owner_req;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        grant_0_d = (state_d == GNT0);
        grant_1_d = (state_d == GNT1);
        mux_sel_d = (state_d == GNT1);
        mux_en_d  = (state_d != IDLE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            timeout_q <= 1'b0;
            grant_0_q <= 1'b0;
            grant_1_q <= 1'b0;
            mux_sel_q <= 1'b0;
            mux_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
            grant_0_q <= grant_0_d;
            grant_1_q <= grant_1_d;
            mux_sel_q <= mux_sel_d;
            mux_en_q  <= mux_en_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.Grant_0   = grant_0_q;
    assign bus.Grant_1   = grant_1_q;
    assign bus.MuxSel    = mux_sel_q;
    assign bus.MuxEnable = mux_en_q;
    assign bus.Timeout   = timeout_q;
    assign bus.Busy      = busy_q;

    // Mutual exclusion of grants and mux enable tracking bus ownership.
    a_one_hot_grant : assert property (@(posedge clock) !(grant_0_q && grant_1_q));
    a_en_matches_busy : assert property (@(posedge clock) mux_en_q == busy_q);

endmodule

// File: tb/tb_mem_bus_arbiter_2.sv
// Scoreboard bench for mem_bus_arbiter_2: each scenario queues per-cycle expected
// outputs as it drives inputs and compares them as the DUT produces them.
module tb_mem_bus_arbiter_2;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    // Output vector layout: {Grant_0, Grant_1, MuxSel, MuxEnable, Timeout, Busy}
    localparam logic [5:0] O_ID = 6'b000000;
    localparam logic [5:0] O_G0 = 6'b100101;
    localparam logic [5:0] O_G1 = 6'b011101;
    localparam logic [5:0] O_TO = 6'b000010;

    logic [5:0] exp_q[$];

    mem_bus_arbiter_2_if bus();

    mem_bus_arbiter_2 #(
        .TIMEOUT_CYCLES(15),
        .CNT_WIDTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [5:0] obs();
        return {bus.Grant_0, bus.Grant_1, bus.MuxSel, bus.MuxEnable, bus.Timeout, bus.Busy};
    endfunction

    // Stimulus entry: {reset, Req_0, Req_1, Done, expected outputs after the next edge}
    function automatic logic [9:0] ent(input logic rst, input logic r0, input logic r1,
                                       input logic d, input logic [5:0] e);
        return {rst, r0, r1, d, e};
    endfunction

    task automatic apply(input logic [9:0] e);
        reset     = e[9];
        bus.Req_0 = e[8];
        bus.Req_1 = e[7];
        bus.Done  = e[6];
        exp_q.push_back(e[5:0]);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.Req_0 = 1'b0;
        bus.Req_1 = 1'b0;
        bus.Done  = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        reset     = 1'b1;
        bus.Req_0 = 1'b1;
        bus.Req_1 = 1'b1;
        bus.Done  = 1'b0;
        repeat (2) @(negedge clock);
        got = obs();
        checks++;
        if (got !== O_ID) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", got, O_ID);
        end
        bus.Req_0 = 1'b0;
        bus.Req_1 = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        got = obs();
        checks++;
        if (got !== O_ID) begin
            errors++;
            $display("FAIL reset_idle got %b exp %b", got, O_ID);
        end
    endtask

    task automatic test_single();
        logic [9:0] t[$];
        logic [5:0] got, e;
        do_reset();
        t.push_back(ent(0, 1, 0, 0, O_G0));
        t.push_back(ent(0, 1, 0, 0, O_G0));
        t.push_back(ent(0, 1, 0, 0, O_G0));
        t.push_back(ent(0, 1, 0, 1, O_ID));
        t.push_back(ent(0, 0, 0, 0, O_ID));
        t.push_back(ent(0, 0, 0, 1, O_ID));
        t.push_back(ent(0, 0, 0, 0, O_ID));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clock);
            got = obs();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single[%0d] got %b exp %b", i, got, e);
            end
        end
    endtask

    task automatic test_fairness();
        logic [9:0] t[$];
        logic [5:0] got, e;
        do_reset();
        for (int g = 0; g < 4; g++) begin
            t.push_back(ent(0, 1, 1, 0, (g % 2 == 0) ? O_G0 : O_G1));
            t.push_back(ent(0, 1, 1, 0, (g % 2 == 0) ? O_G0 : O_G1));
            t.push_back(ent(0, 1, 1, 1, O_ID));
        end
        t.push_back(ent(0, 0, 0, 0, O_ID));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clock);
            got = obs();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL fairness[%0d] got %b exp %b", i, got, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0] t[$];
        logic [5:0] got, e;
        do_reset();
        for (int k = 0; k < 15; k++) t.push_back(ent(0, 0, 1, 0, O_G1));
        t.push_back(ent(0, 0, 1, 0, O_TO));
        t.push_back(ent(0, 0, 1, 0, O_G1));
        t.push_back(ent(0, 0, 0, 0, O_ID));
        t.push_back(ent(0, 0, 0, 0, O_ID));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clock);
            got = obs();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL timeout[%0d] got %b exp %b", i, got, e);
            end
        end
    endtask

    task automatic test_done_at_limit();
        logic [9:0] t[$];
        logic [5:0] got, e;
        do_reset();
        for (int k = 0; k < 15; k++) t.push_back(ent(0, 1, 0, 0, O_G0));
        t.push_back(ent(0, 1, 0, 1, O_ID));
        t.push_back(ent(0, 0, 0, 0, O_ID));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clock);
            got = obs();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL done_at_limit[%0d] got %b exp %b", i, got, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [9:0] t[$];
        logic [5:0] got, e;
        do_reset();
        t.push_back(ent(0, 1, 0, 0, O_G0));
        t.push_back(ent(0, 1, 1, 0, O_G0));
        t.push_back(ent(0, 0, 1, 0, O_ID));
        t.push_back(ent(0, 0, 1, 0, O_G1));
        t.push_back(ent(0, 0, 1, 1, O_ID));
        t.push_back(ent(0, 0, 0, 0, O_ID));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clock);
            got = obs();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL abort[%0d] got %b exp %b", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [9:0] t[$];
        logic [5:0] got, e;
        do_reset();
        t.push_back(ent(0, 0, 1, 0, O_G1));
        t.push_back(ent(0, 0, 1, 0, O_G1));
        t.push_back(ent(1, 0, 1, 1, O_ID));
        t.push_back(ent(0, 1, 1, 0, O_G0));
        t.push_back(ent(0, 1, 1, 1, O_ID));
        t.push_back(ent(0, 1, 1, 0, O_G1));
        t.push_back(ent(0, 0, 0, 0, O_ID));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clock);
            got = obs();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_grant[%0d] got %b exp %b", i, got, e);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.Req_0 = 1'b0;
        bus.Req_1 = 1'b0;
        bus.Done  = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_done_at_limit();
        test_abort();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
